dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port data RAM.
- Requester 0 is the CPU memory stage. Requester 1 is the debug/program-loader port.
- Per access, the block checks alignment and range, grants one requester using round-robin, drives the RAM enables, and returns a one-cycle response pulse with read data or an error flag.
- It replaces direct RAM drive by the memory stage. The CPU stalls on cpu_req_i && !cpu_rvalid_o.

Parameters:
- MEM_BYTES, 1024, RAM size in bytes; the legal address range is 0..MEM_BYTES-1.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous active-high reset.
- cpu_req_i  in  1  CPU request; held until cpu_rvalid_o.
- cpu_we_i  in  1  1 = store, 0 = load.
- cpu_funct_i  in  10  access-size funct code (FUNC_LW/LH/LHU/LB/LBU/SW/SH/SB).
- cpu_addr_i  in  ADDR_W  byte address.
- cpu_wdata_i  in  DATA_W  store data.
- cpu_gnt_o  out  1  pulse: CPU request accepted this cycle.
- cpu_rvalid_o  out  1  pulse: CPU response valid.
- cpu_rdata_o  out  DATA_W  load data; 0 for stores and errors.
- cpu_err_o  out  1  qualified by cpu_rvalid_o: misaligned or out-of-range access.
- dbg_req_i, dbg_we_i, dbg_funct_i, dbg_addr_i, dbg_wdata_i  in  same widths as the cpu_* inputs  debug requester inputs.
- dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o, dbg_err_o  out  same widths as the cpu_* outputs  debug requester outputs.
- ram_r_en_o  out  1  RAM read enable.
- ram_w_en_o  out  1  RAM write enable.
- ram_funct_o  out  10  funct to RAM.
- ram_addr_o  out  ADDR_W  address to RAM.
- ram_wdata_o  out  DATA_W  write data to RAM.
- ram_rdata_i  in  DATA_W  RAM read data, valid in the same cycle as ram_r_en_o.

Behaviour:
- Clock and reset: one clock, clk_i; reset is synchronous and active-high, rst_i.
- Reset values:
  - state=IDLE, last_winner=1 (so the CPU wins the first tie).
  - All gnt, rvalid, err, ram enables = 0.
  - All rdata and ram_addr/wdata/funct = 0.
- FSM state IDLE:
  - If no req: stay in IDLE with all outputs 0.
  - If any req: select the winner combinationally.
    - Exactly one requester: that requester wins.
    - Both requesting: the one not equal to last_winner wins.
  - Assert winner gnt_o this same cycle. Latch the winner id, we, and the error flag. Update last_winner. Go to ACCESS.
- FSM state ACCESS (1 cycle):
  - Drive ram_* from the latched winner's live inputs. Requesters hold their inputs until rvalid.
  - ram_r_en_o = !we && !err; ram_w_en_o = we && !err. If err, neither enable is asserted and the RAM is untouched.
  - Register ram_rdata_i (loads only, else 0) into the winner's rdata. Go to RESP.
- FSM state RESP (1 cycle):
  - Pulse the winner's rvalid_o and err_o. rdata_o is held until the next rvalid for that port.
  - Go to IDLE.
- Timing:
  - Latency from req seen to rvalid is 2 cycles: gnt in cycle N, rvalid in cycle N+2.
  - Peak throughput is one access per 3 cycles.
  - A new grant is never issued in ACCESS or RESP.
- Error rule (evaluated in IDLE on the winner's inputs):
  - Misaligned: FUNC_LW/FUNC_SW with addr[1:0]!=0, or FUNC_LH/FUNC_LHU/FUNC_SH with addr[0]!=0.
  - Out of range: addr > MEM_BYTES-1, compared at the full ADDR_W width with no truncation.
  - err = misaligned OR out of range. Byte accesses are never misaligned.
- Fairness:
  - A single continuous requester is granted back-to-back every 3 cycles.
  - With both requesting continuously, grants strictly alternate and neither waits more than one transaction.
- Request withdrawal: a req dropped before gnt is legal and ignored. A req dropped after gnt is a protocol violation; the transaction still completes.
- Reset mid-operation: rst_i in ACCESS or RESP aborts the transaction. No rvalid is issued, no RAM write occurs in the reset cycle, and outputs return to reset values next cycle.
- Invariants:
  - gnt and rvalid are one-hot across the two ports.
  - ram_r_en_o and ram_w_en_o are never both 1.

Decomposition:
- define.v holds:
  - FUNC_* codes and OP_LOAD/OP_S, already shared.
  - New FSM state encodings ARB_IDLE/ARB_ACCESS/ARB_RESP (2 bits).
  - Requester ids REQ_CPU=0, REQ_DBG=1.
- One natural sub-module: dmem_access_check, a combinational block computing err from funct, addr, and MEM_BYTES. It is reusable by the memory stage.
- The round-robin pick stays inline.

Test Plan:
- Single CPU load: cpu_req=1, we=0, FUNC_LW, addr=0x10, RAM word 0xDEADBEEF → cpu_gnt at cycle 1, ram_r_en at cycle 2 with addr 0x10, cpu_rvalid=1, rdata=0xDEADBEEF, err=0 at cycle 3.
- Simultaneous requests after reset, both held for 12 cycles → grant order CPU, DBG, CPU, DBG at cycles 1/4/7/10; rvalid follows each grant by 2 cycles.
- Misaligned store: dbg FUNC_SW addr=0x102 → dbg_err=1 with rvalid, ram_w_en never asserted, RAM word 0x100 unchanged. Repeat with FUNC_SB addr=0x103 → err=0, write occurs.
- Out of range: CPU FUNC_LW addr=0x400 (MEM_BYTES=1024) → err=1, rdata=0, ram_r_en=0. addr=0x3FC → err=0.
- Reset in ACCESS: CPU store grant, then rst_i=1 in the ACCESS cycle → no ram_w_en, no cpu_rvalid, all outputs 0 in the next cycle. After reset, DBG alone is granted first on the next request.
- Store then load: CPU FUNC_SH addr=0x20 wdata=0x1234, then FUNC_LHU addr=0x20 → second response rdata=0x00001234 with err=0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: access-size funct codes,
// arbiter FSM state encodings and requester ids.
// Funct codes are {opcode, funct3}, so loads and stores never share a code.
package dmem_arbiter_pkg;

  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;

  localparam logic [9:0] FUNC_LB  = {OP_LOAD, 3'b000};
  localparam logic [9:0] FUNC_LH  = {OP_LOAD, 3'b001};
  localparam logic [9:0] FUNC_LW  = {OP_LOAD, 3'b010};
  localparam logic [9:0] FUNC_LBU = {OP_LOAD, 3'b100};
  localparam logic [9:0] FUNC_LHU = {OP_LOAD, 3'b101};
  localparam logic [9:0] FUNC_SB  = {OP_S,    3'b000};
  localparam logic [9:0] FUNC_SH  = {OP_S,    3'b001};
  localparam logic [9:0] FUNC_SW  = {OP_S,    3'b010};

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester's connection to the data-memory arbiter.
// master: requester side (req/we/funct/addr/wdata out; gnt/rvalid/rdata/err in).
// slave:  arbiter side, the mirror image.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [9:0]        funct;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (
    output req, we, funct, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, funct, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/dmem_access_check.sv
// Combinational legality check for one data-memory access.
// Ports: i_funct (access-size funct), i_addr (byte address),
//        o_err (1 = misaligned or outside 0..MEM_BYTES-1).
module dmem_access_check
  import dmem_arbiter_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic [9:0]        i_funct,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 1);

  logic w_word;
  logic w_half;
  logic w_misaligned;
  logic w_out_of_range;

  assign w_word = (i_funct == FUNC_LW) || (i_funct == FUNC_SW);
  assign w_half = (i_funct == FUNC_LH) || (i_funct == FUNC_LHU) || (i_funct == FUNC_SH);

  // Byte accesses fall through both terms and are never misaligned.
  assign w_misaligned = (w_word && (i_addr[1:0] != 2'b00)) || (w_half && i_addr[0]);

  // Full-width compare: high address bits must not alias back into the RAM.
  assign w_out_of_range = i_addr > LAST_ADDR;

  assign o_err = w_misaligned || w_out_of_range;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer between the CPU memory stage and the debug
// port in front of the single-port data RAM. Grant in IDLE, RAM access one
// cycle later, one-cycle response pulse two cycles after grant.
// Ports: clk_i/rst_i (sync, active-high), cpu/dbg requester interfaces,
//        ram_* RAM control/data, ram_rdata_i read data (same cycle as ram_r_en_o).
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  dmem_arbiter_if.slave     cpu,
  dmem_arbiter_if.slave     dbg,
  output logic              ram_r_en_o,
  output logic              ram_w_en_o,
  output logic [9:0]        ram_funct_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              r_last;
  logic              r_win;
  logic              r_we;
  logic              r_err;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dbg_rdata;

  logic              w_any;
  logic              w_win;
  logic              w_sel_we;
  logic [9:0]        w_sel_funct;
  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_chk_err;
  logic              w_grant;
  logic              w_access;
  logic              w_resp;
  logic [DATA_W-1:0] w_load_dat;

  // Round-robin pick: on a tie the requester that did not win last time goes.
  assign w_any = cpu.req || dbg.req;

  always_comb begin
    w_win = REQ_CPU;
    if (cpu.req && dbg.req) begin
      w_win = ~r_last;
    end else if (dbg.req) begin
      w_win = REQ_DBG;
    end
  end

  assign w_sel_we    = (w_win == REQ_DBG) ? dbg.we    : cpu.we;
  assign w_sel_funct = (w_win == REQ_DBG) ? dbg.funct : cpu.funct;
  assign w_sel_addr  = (w_win == REQ_DBG) ? dbg.addr  : cpu.addr;

  dmem_access_check #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_access_check (
    .i_funct (w_sel_funct),
    .i_addr  (w_sel_addr),
    .o_err   (w_chk_err)
  );

  // Next state and phase strobes. Everything is suppressed while rst_i is
  // high so an aborted transaction neither writes the RAM nor responds.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_access    = 1'b0;
    w_resp      = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_any) begin
          w_grant     = !rst_i;
          w_state_nxt = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        w_access    = !rst_i;
        w_state_nxt = ARB_RESP;
      end
      ARB_RESP: begin
        w_resp      = !rst_i;
        w_state_nxt = ARB_IDLE;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  assign cpu.gnt = w_grant && (w_win == REQ_CPU);
  assign dbg.gnt = w_grant && (w_win == REQ_DBG);

  // RAM is driven from the winner's live inputs; requesters hold them until rvalid.
  assign ram_funct_o = !w_access ? '0 : ((r_win == REQ_DBG) ? dbg.funct : cpu.funct);
  assign ram_addr_o  = !w_access ? '0 : ((r_win == REQ_DBG) ? dbg.addr  : cpu.addr);
  assign ram_wdata_o = !w_access ? '0 : ((r_win == REQ_DBG) ? dbg.wdata : cpu.wdata);
  assign ram_r_en_o  = w_access && !r_we && !r_err;
  assign ram_w_en_o  = w_access &&  r_we && !r_err;

  // Stores and rejected loads return zero data.
  assign w_load_dat = ram_r_en_o ? ram_rdata_i : '0;

  assign cpu.rvalid = w_resp && (r_win == REQ_CPU);
  assign dbg.rvalid = w_resp && (r_win == REQ_DBG);
  assign cpu.err    = cpu.rvalid && r_err;
  assign dbg.err    = dbg.rvalid && r_err;
  assign cpu.rdata  = r_cpu_rdata;
  assign dbg.rdata  = r_dbg_rdata;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ARB_IDLE;
      r_last      <= REQ_DBG;
      r_win       <= REQ_CPU;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ARB_IDLE) && w_any) begin
        r_win  <= w_win;
        r_last <= w_win;
        r_we   <= w_sel_we;
        r_err  <= w_chk_err;
      end
      // Loaded in ACCESS so the new data appears exactly with rvalid.
      if (r_state == ARB_ACCESS) begin
        if (r_win == REQ_CPU) begin
          r_cpu_rdata <= w_load_dat;
        end else begin
          r_dbg_rdata <= w_load_dat;
        end
      end
    end
  end

endmodule
